outpass4_frame_config_ce: RTL
=============================

# outpass4_frame_config_ce

Fabric-to-pad output-pass BEL: the outbound counterpart of the tile's 4-lane input-pass BEL. It takes four signals from the switch matrix and drives them to four EXTERNAL top-level pins. Each lane has a frame-configured output mode: combinational, registered, registered with clock enable, or two-stage retimed. It sits in the RAM_IO tile beside the input-pass BELs and shares their UserCLK.

## Interface
Parameters:
- NoConfigBits, 8, configuration bits; 2 per lane, lane k uses ConfigBits[2k+1:2k].

Ports:
- UserCLK  input  1  fabric user clock; EXTERNAL, SHARED_PORT.
- RST  input  1  reset, asynchronous, active-high; EXTERNAL, SHARED_PORT. Clears all flops.
- I  input  4  data from the switch matrix, one bit per lane.
- CE  input  1  clock enable from the switch matrix; shared by all lanes, used only in mode 10.
- O  output  4  data to the top-level pins; EXTERNAL.
- ConfigBits  input  NoConfigBits  GLOBAL frame config, static during user operation.

BelMap: O0_cfg0=0, O0_cfg1=1, O1_cfg0=2, O1_cfg1=3, O2_cfg0=4, O2_cfg1=5, O3_cfg0=6, O3_cfg1=7.

## Operation
- Each lane k has two flops: S1[k] (capture) and S2[k] (retime). Both reset to 0 on RST.
- The lane mode is m = ConfigBits[2k+1:2k]:
  - 00 combinational: O[k] = I[k]. The flops keep clocking but are unused.
  - 01 registered: S1[k] loads I[k] on every edge; O[k] = S1[k].
  - 10 registered with CE: S1[k] loads I[k] only on an edge where CE=1, otherwise it holds; O[k] = S1[k].
  - 11 retimed: S1[k] loads I[k] on every edge; S2[k] loads S1[k] on every edge; O[k] = S2[k]. CE is ignored.
- S1 enable = CE when m==10, otherwise 1.
- S2 loads S1 on every edge in all modes.
- Output selection is built from cus_mux21 cells in two levels:
  - first level selects S1 or S2 on cfg1 & cfg0;
  - second level selects I or the flop path on (cfg1 | cfg0).
  - No behavioural ternary on the output path.
- Lanes are fully independent, except that they share CE, UserCLK and RST.
- No state machine beyond the per-lane flops. There is no handshake; CE is a level qualifier sampled at the rising edge.

## Timing
- Reset values:
  - while RST=1, O[k]=0 for modes 01, 10 and 11;
  - while RST=1, O[k]=I[k] for mode 00 (the path is combinational and unaffected by reset).
- RST assertion clears S1 and S2 immediately, without waiting for a clock edge.
- Deassertion occurs between edges. The first edge after it is the first capture edge.
- Latency from I to O:
  - mode 00: 0 cycles;
  - modes 01 and 10 (with CE=1): 1 cycle, O(n+1)=I(n);
  - mode 11: 2 cycles, O(n+2)=I(n).
- Mode 10 with CE=0 holds O indefinitely. The output changes only on an edge where CE=1 is sampled.
- Reset mid-stream:
  - mode 11 outputs 0 for the first edge after deassertion, because S2 loads the reset value of S1;
  - real data appears on the second edge.
- Simultaneous RST=1 and a clock edge: reset wins and the flops stay 0.
- A config change while running takes effect combinationally. O immediately shows the selected source's current contents, with no extra cycle.
- Switching from mode 10 to mode 01 exposes the held S1 value until the next edge.

## Test plan
- Reset/defaults: ConfigBits=8'h00, RST=1, I=4'b1010 -> O=4'b1010. Then ConfigBits=8'h55 with RST=1 -> O=4'b0000.
- Mode 01 latency: ConfigBits=8'h55, release RST, drive I=1,2,4,8 on successive edges -> O shows each value exactly one edge later.
- Mode 10 hold:
  - ConfigBits=8'hAA, I=4'hF, CE=0 for 5 edges -> O stays 4'h0;
  - assert CE for one edge -> O=4'hF;
  - then I=4'h0 with CE=0 -> O stays 4'hF.
- Mode 11 latency and reset recovery:
  - ConfigBits=8'hFF, I=4'h5 held, release RST -> O=0 after edge 1, O=4'h5 after edge 2;
  - assert RST asynchronously mid-cycle -> O drops to 0 before the next edge.
- Mixed lanes: ConfigBits=8'b11_10_01_00, CE=0, step I from 4'h0 to 4'hF -> after the step edge:
  - lane0=1 immediately;
  - lane1=1 after 1 edge;
  - lane2 stays 0;
  - lane3=1 after 2 edges.
- Live reconfig: in mode 10 with S1=1 held and I=0, rewrite to mode 01 -> O=1 until the next edge, then O=0.

Source files
------------

// File: rtl/outpass4_frame_config_ce.sv
// Four-lane fabric-to-pad output pass: each lane is combinational, registered, CE-registered or two-stage retimed.
// Latency 0/1/1/2 edges by mode; no handshake, CE only qualifies the capture flop in mode 10.

module cus_mux21 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);
  assign X = (A0 & ~S) | (A1 & S);
endmodule

module outpass4_frame_config_ce #(
  parameter int NoConfigBits = 8
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic [3:0]              I,
  input  logic                    CE,
  output logic [3:0]              O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [3:0] flop_path;

  // Only mode 10 gates capture with CE; every other mode captures each edge.
  always_comb begin
    s1_d = s1_q;
    for (int k = 0; k < 4; k++) begin
      if (!(ConfigBits[2*k+1] && !ConfigBits[2*k]) || CE) begin
        s1_d[k] = I[k];
      end
    end
    s2_d = s1_q;
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_lane
      cus_mux21 u_flop_sel (
        .A0 (s1_q[k]),
        .A1 (s2_q[k]),
        .S  (ConfigBits[2*k+1] & ConfigBits[2*k]),
        .X  (flop_path[k])
      );
      cus_mux21 u_out_sel (
        .A0 (I[k]),
        .A1 (flop_path[k]),
        .S  (ConfigBits[2*k+1] | ConfigBits[2*k]),
        .X  (O[k])
      );
    end
  endgenerate

endmodule
